power_mode_controller: RTL and testbench

Parametrised successor to the simulator's inline OFF/ACC/RUN ignition logic. It debounces the start key and adds a timed CRANK phase, an ACC auto-off timeout, a fuel-empty stall path and a long-press emergency shutdown. Gear, brake and speed interlocks are configurable. Sits between keypad/Vehicle_Logic and every consumer of engine_on (display, LCD, sound, LED masking).

---
 rtl/car_pkg.sv | 23 ++
 rtl/key_debouncer.sv | 63 ++++++
 rtl/power_mode_controller.sv | 209 ++++++++++++++++++++
 tb/tb_power_mode_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Shared vehicle-level encodings used by the power mode controller and the
// key/gear input logic.
//   pwr_state_e : power state encoding. OFF/ACC/RUN keep the legacy values
//                 0/1/2 so existing consumers still decode them; CRANK is 3.
//   GEAR_*      : gear codes as presented on the gear bus.
// -----------------------------------------------------------------------------
package car_pkg;

  typedef enum logic [1:0] {
    PWR_OFF   = 2'd0,
    PWR_ACC   = 2'd1,
    PWR_RUN   = 2'd2,
    PWR_CRANK = 2'd3
  } pwr_state_e;

  localparam int GEAR_P = 3;
  localparam int GEAR_R = 6;
  localparam int GEAR_N = 9;
  localparam int GEAR_D = 12;

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Debounces a raw push-key by sampling it only on a slow tick strobe. The
// debounced level flips once DEBOUNCE_TICKS consecutive samples disagree with
// it; any agreeing sample restarts the count.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-clk sampling strobe
//   raw   : raw key input, active high
//   level : debounced key level
//   rise  : one-clk pulse in the clk following the edge where level rose
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (tick) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CW'(DEBOUNCE_TICKS - 1)) begin
        // This sample completes the run of disagreeing samples.
        level_d = raw;
        cnt_d   = '0;
        rise_d  = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/power_mode_controller.sv
// -----------------------------------------------------------------------------
// power_mode_controller
// Ignition power state machine OFF / ACC / CRANK / RUN with a debounced start
// key, timed crank phase, ACC auto-off, fuel stall and long-press emergency
// shutdown while moving.
//   clk, rst_n    : clock, asynchronous active-low reset
//   tick_50ms     : one-clk strobe, 50 ms period (debounce, crank, hold timing)
//   tick_1sec     : one-clk strobe, 1 s period (ACC timeout)
//   key_start     : raw start key
//   brake         : service brake held
//   gear          : gear code (P=3, R=6, N=9, D=12)
//   speed         : vehicle speed
//   fuel_empty    : fuel level is zero
//   power_state   : current power state (OFF=0, ACC=1, RUN=2, CRANK=3)
//   engine_on     : state is RUN
//   acc_on        : state is ACC, CRANK or RUN
//   crank_active  : state is CRANK
//   start_denied  : one-clk pulse when a braked start request is rejected
//   disp_off      : state is OFF
// -----------------------------------------------------------------------------
module power_mode_controller
  import car_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = 2,
  parameter int CRANK_TICKS      = 10,
  parameter int ACC_TIMEOUT_S    = 60,
  parameter int LONG_PRESS_TICKS = 40,
  parameter int GEAR_W           = 4,
  parameter int SPD_W            = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_50ms,
  input  logic              tick_1sec,
  input  logic              key_start,
  input  logic              brake,
  input  logic [GEAR_W-1:0] gear,
  input  logic [SPD_W-1:0]  speed,
  input  logic              fuel_empty,
  output logic [1:0]        power_state,
  output logic              engine_on,
  output logic              acc_on,
  output logic              crank_active,
  output logic              start_denied,
  output logic              disp_off
);

  localparam int CRANK_W = $clog2(CRANK_TICKS + 1);
  localparam int ACC_W   = $clog2(ACC_TIMEOUT_S + 1);
  localparam int HOLD_W  = $clog2(LONG_PRESS_TICKS + 1);

  pwr_state_e         state_q, state_d;
  logic [CRANK_W-1:0] crank_cnt_q, crank_cnt_d;
  logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               engine_on_q, engine_on_d;
  logic               acc_on_q, acc_on_d;
  logic               crank_q, crank_d;
  logic               disp_off_q, disp_off_d;
  logic               denied_q, denied_d;

  logic key_db;
  logic key_press;
  logic start_ok;
  logic moving;
  logic crank_expire;
  logic acc_expire;
  logic hold_expire;

  key_debouncer #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_key_db (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_50ms),
    .raw   (key_start),
    .level (key_db),
    .rise  (key_press)
  );

  assign start_ok = brake & ~fuel_empty &
                    ((gear == GEAR_W'(GEAR_P)) | (gear == GEAR_W'(GEAR_N)));
  assign moving   = (speed != '0);

  // Timer events fire on the tick that would bring the count to its limit.
  assign crank_expire = tick_50ms & (crank_cnt_q >= CRANK_W'(CRANK_TICKS - 1));
  assign acc_expire   = tick_1sec & (acc_cnt_q >= ACC_W'(ACC_TIMEOUT_S - 1));
  assign hold_expire  = tick_50ms & key_db & moving &
                        (hold_cnt_q >= HOLD_W'(LONG_PRESS_TICKS - 1));

  // Next-state logic. Within a state: press first, then stall/abort, then timers.
  always_comb begin
    state_d  = state_q;
    denied_d = 1'b0;
    case (state_q)
      PWR_OFF: begin
        if (key_press) begin
          if (start_ok) begin
            state_d = PWR_CRANK;
          end else begin
            state_d  = PWR_ACC;
            denied_d = brake;
          end
        end
      end
      PWR_ACC: begin
        if (key_press) begin
          if (start_ok) begin
            state_d = PWR_CRANK;
          end else if (brake) begin
            denied_d = 1'b1;
          end else begin
            state_d = PWR_OFF;
          end
        end else if (acc_expire) begin
          state_d = PWR_OFF;
        end
      end
      PWR_CRANK: begin
        // Gear is deliberately not re-checked once cranking has started.
        if (!brake || fuel_empty) begin
          state_d  = PWR_ACC;
          denied_d = fuel_empty;
        end else if (crank_expire) begin
          state_d = PWR_RUN;
        end
      end
      PWR_RUN: begin
        if (key_press && !moving) begin
          state_d = PWR_OFF;
        end else if (fuel_empty) begin
          state_d = PWR_ACC;
        end else if (hold_expire) begin
          state_d = PWR_OFF;
        end
      end
      default: state_d = PWR_OFF;
    endcase
  end

  // Counters only run while the FSM stays in their state; any transition
  // (including re-entry) leaves them cleared. All saturate at their limit.
  always_comb begin
    crank_cnt_d = '0;
    acc_cnt_d   = '0;
    hold_cnt_d  = '0;

    if (state_q == PWR_CRANK && state_d == PWR_CRANK) begin
      crank_cnt_d = crank_cnt_q;
      if (tick_50ms && crank_cnt_q != CRANK_W'(CRANK_TICKS)) begin
        crank_cnt_d = crank_cnt_q + 1'b1;
      end
    end

    if (state_q == PWR_ACC && state_d == PWR_ACC && !key_press) begin
      acc_cnt_d = acc_cnt_q;
      if (tick_1sec && acc_cnt_q != ACC_W'(ACC_TIMEOUT_S)) begin
        acc_cnt_d = acc_cnt_q + 1'b1;
      end
    end

    if (state_q == PWR_RUN && state_d == PWR_RUN && key_db) begin
      hold_cnt_d = hold_cnt_q;
      if (tick_50ms && moving && hold_cnt_q != HOLD_W'(LONG_PRESS_TICKS)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  // Output decode from the next state so the registered flags track state_q.
  always_comb begin
    engine_on_d = (state_d == PWR_RUN);
    acc_on_d    = (state_d != PWR_OFF);
    crank_d     = (state_d == PWR_CRANK);
    disp_off_d  = (state_d == PWR_OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_OFF;
      crank_cnt_q <= '0;
      acc_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      engine_on_q <= 1'b0;
      acc_on_q    <= 1'b0;
      crank_q     <= 1'b0;
      disp_off_q  <= 1'b1;
      denied_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crank_cnt_q <= crank_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      engine_on_q <= engine_on_d;
      acc_on_q    <= acc_on_d;
      crank_q     <= crank_d;
      disp_off_q  <= disp_off_d;
      denied_q    <= denied_d;
    end
  end

  assign power_state  = state_q;
  assign engine_on    = engine_on_q;
  assign acc_on       = acc_on_q;
  assign crank_active = crank_q;
  assign start_denied = denied_q;
  assign disp_off     = disp_off_q;

endmodule

// File: tb/tb_power_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_power_mode_controller
// Directed bench for power_mode_controller with short timer parameters
// (DEBOUNCE_TICKS=2, CRANK_TICKS=4, ACC_TIMEOUT_S=3, LONG_PRESS_TICKS=6).
// Each table row is one clock: inputs applied, one rising edge, outputs
// compared one time unit later. Hand-written sequences follow for the
// multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_power_mode_controller;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_CRANK = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_50ms = 1'b0;
  logic       tick_1sec = 1'b0;
  logic       key_start = 1'b0;
  logic       brake = 1'b0;
  logic [3:0] gear = 4'd0;
  logic [7:0] speed = 8'd0;
  logic       fuel_empty = 1'b0;
  logic [1:0] power_state;
  logic       engine_on, acc_on, crank_active, start_denied, disp_off;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  power_mode_controller #(
    .DEBOUNCE_TICKS   (2),
    .CRANK_TICKS      (4),
    .ACC_TIMEOUT_S    (3),
    .LONG_PRESS_TICKS (6),
    .GEAR_W           (4),
    .SPD_W            (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_50ms    (tick_50ms),
    .tick_1sec    (tick_1sec),
    .key_start    (key_start),
    .brake        (brake),
    .gear         (gear),
    .speed        (speed),
    .fuel_empty   (fuel_empty),
    .power_state  (power_state),
    .engine_on    (engine_on),
    .acc_on       (acc_on),
    .crank_active (crank_active),
    .start_denied (start_denied),
    .disp_off     (disp_off)
  );

  typedef struct {
    logic       key;
    logic       brk;
    logic [3:0] gr;
    logic       fuel;
    logic       t50;
    logic       t1;
    logic [1:0] st;
    logic       den;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic k, input logic b, input logic [3:0] g,
                     input logic f, input logic t5, input logic t1,
                     input logic [1:0] st, input logic den);
    vec_t v;
    v.key = k; v.brk = b; v.gr = g; v.fuel = f;
    v.t50 = t5; v.t1 = t1; v.st = st; v.den = den;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] est, input logic eden);
    logic [5:0] act;
    logic [5:0] exp;
    act = {power_state, engine_on, acc_on, crank_active, disp_off, start_denied};
    exp = {est, est == S_RUN, est != S_OFF, est == S_CRANK, est == S_OFF, eden};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {state,eng,acc,crank,doff,denied} got %b expected %b",
               name, act, exp);
    end
  endtask

  // One clock with the given strobes; outputs settle 1 time unit after the edge.
  task automatic clk1(input logic t5, input logic t1);
    tick_50ms = t5;
    tick_1sec = t1;
    @(posedge clk);
    #1;
    tick_50ms = 1'b0;
    tick_1sec = 1'b0;
  endtask

  // Hold key through two debounce ticks, then the clock that applies the press.
  task automatic press();
    key_start = 1'b1;
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
    clk1(1'b0, 1'b0);
  endtask

  task automatic release_key();
    key_start = 1'b0;
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk(name, S_OFF, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // key, brake, gear, fuel, t50, t1, expected state, expected denied
    add(1, 0,  0, 0, 1, 0, S_OFF,   0); // single high sample
    add(0, 0,  0, 0, 0, 0, S_OFF,   0);
    add(0, 0,  0, 0, 1, 0, S_OFF,   0); // glitch discarded
    add(1, 0,  0, 0, 1, 0, S_OFF,   0);
    add(1, 0,  0, 0, 1, 0, S_OFF,   0); // debounce completes
    add(1, 0,  0, 0, 0, 0, S_ACC,   0); // press one clk later
    add(1, 0,  0, 0, 0, 0, S_ACC,   0);
    add(0, 0,  0, 0, 1, 0, S_ACC,   0);
    add(0, 0,  0, 0, 1, 0, S_ACC,   0);
    add(0, 0,  0, 0, 0, 1, S_ACC,   0);
    add(0, 0,  0, 0, 0, 1, S_ACC,   0);
    add(0, 0,  0, 0, 0, 1, S_OFF,   0); // ACC timeout
    add(1, 1,  3, 0, 1, 0, S_OFF,   0);
    add(1, 1,  3, 0, 1, 0, S_OFF,   0);
    add(1, 1,  3, 0, 0, 0, S_CRANK, 0);
    add(1, 1,  3, 0, 1, 0, S_CRANK, 0);
    add(1, 1,  3, 0, 1, 0, S_CRANK, 0);
    add(1, 1,  3, 0, 1, 0, S_CRANK, 0);
    add(1, 1,  3, 0, 1, 0, S_RUN,   0); // 4th crank tick
    add(0, 1,  3, 0, 1, 0, S_RUN,   0);
    add(0, 1,  3, 0, 1, 0, S_RUN,   0);
    add(1, 1,  3, 0, 1, 0, S_RUN,   0);
    add(1, 1,  3, 0, 1, 0, S_RUN,   0);
    add(1, 1,  3, 0, 0, 0, S_OFF,   0); // press at standstill
    add(0, 1,  3, 0, 1, 0, S_OFF,   0);
    add(0, 1,  3, 0, 1, 0, S_OFF,   0);
    add(1, 1, 12, 0, 1, 0, S_OFF,   0);
    add(1, 1, 12, 0, 1, 0, S_OFF,   0);
    add(1, 1, 12, 0, 0, 0, S_ACC,   1); // gear D rejected
    add(1, 1, 12, 0, 0, 0, S_ACC,   0);
    add(0, 1, 12, 0, 1, 0, S_ACC,   0);
    add(0, 1, 12, 0, 1, 0, S_ACC,   0);
    add(1, 0, 12, 0, 1, 0, S_ACC,   0);
    add(1, 0, 12, 0, 1, 0, S_ACC,   0);
    add(1, 0, 12, 0, 0, 0, S_OFF,   0); // ACC press without brake
    add(0, 0, 12, 0, 1, 0, S_OFF,   0);
    add(0, 0, 12, 0, 1, 0, S_OFF,   0);
    add(1, 1,  9, 1, 1, 0, S_OFF,   0);
    add(1, 1,  9, 1, 1, 0, S_OFF,   0);
    add(1, 1,  9, 1, 0, 0, S_ACC,   1); // fuel empty rejected
    add(1, 1,  9, 1, 0, 0, S_ACC,   0);
    add(0, 1,  9, 1, 1, 0, S_ACC,   0);
    add(0, 1,  9, 1, 1, 0, S_ACC,   0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", S_OFF, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_start  = vecs[i].key;
      brake      = vecs[i].brk;
      gear       = vecs[i].gr;
      fuel_empty = vecs[i].fuel;
      clk1(vecs[i].t50, vecs[i].t1);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].den);
    end

    // Crank abort by brake release; a gear change does not abort.
    key_start = 1'b0; fuel_empty = 1'b0; brake = 1'b0; gear = 4'd0;
    pulse_reset("reset_async");
    brake = 1'b1; gear = 4'd3;
    press();
    chk("crank_entry", S_CRANK, 1'b0);
    clk1(1'b1, 1'b0);
    gear = 4'd12;
    clk1(1'b1, 1'b0);
    chk("crank_gear_change", S_CRANK, 1'b0);
    brake = 1'b0;
    clk1(1'b0, 1'b0);
    chk("crank_brake_abort", S_ACC, 1'b0);
    release_key();

    // ACC -> CRANK, then fuel abort with a single denied pulse.
    brake = 1'b1; gear = 4'd3;
    press();
    chk("acc_to_crank", S_CRANK, 1'b0);
    fuel_empty = 1'b1;
    clk1(1'b0, 1'b0);
    chk("crank_fuel_abort", S_ACC, 1'b1);
    clk1(1'b0, 1'b0);
    chk("denied_one_clk", S_ACC, 1'b0);
    fuel_empty = 1'b0;
    release_key();

    // Press on the same clk as the timeout, brake released -> OFF.
    brake = 1'b0;
    clk1(1'b0, 1'b1);
    clk1(1'b0, 1'b1);
    key_start = 1'b1;
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
    chk("acc_pre_timeout", S_ACC, 1'b0);
    clk1(1'b0, 1'b1);
    chk("press_timeout_off", S_OFF, 1'b0);
    release_key();

    // Press on the timeout clk with a valid start -> CRANK wins.
    press();
    chk("off_to_acc", S_ACC, 1'b0);
    release_key();
    clk1(1'b0, 1'b1);
    clk1(1'b0, 1'b1);
    brake = 1'b1; gear = 4'd3;
    key_start = 1'b1;
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
    clk1(1'b0, 1'b1);
    chk("press_beats_timeout", S_CRANK, 1'b0);
    for (int i = 0; i < 3; i++) clk1(1'b1, 1'b0);
    chk("crank_3_ticks", S_CRANK, 1'b0);
    clk1(1'b1, 1'b0);
    chk("crank_to_run", S_RUN, 1'b0);
    release_key();

    // Moving: short press ignored, long hold forces OFF.
    speed = 8'd40;
    press();
    chk("run_press_moving", S_RUN, 1'b0);
    release_key();
    chk("run_short_release", S_RUN, 1'b0);
    press();
    for (int i = 0; i < 5; i++) clk1(1'b1, 1'b0);
    chk("run_hold_5", S_RUN, 1'b0);
    clk1(1'b1, 1'b0);
    chk("run_long_press", S_OFF, 1'b0);
    speed = 8'd0;
    release_key();

    // Fuel stall from RUN.
    press();
    for (int i = 0; i < 4; i++) clk1(1'b1, 1'b0);
    chk("run_again", S_RUN, 1'b0);
    fuel_empty = 1'b1;
    clk1(1'b0, 1'b0);
    chk("run_fuel_stall", S_ACC, 1'b0);
    fuel_empty = 1'b0;
    release_key();

    // Reset mid-CRANK, then verify debouncer and crank counter restart.
    press();
    clk1(1'b1, 1'b0);
    chk("crank_before_rst", S_CRANK, 1'b0);
    pulse_reset("rst_mid_crank");
    clk1(1'b1, 1'b0);
    chk("rst_key_db_cleared", S_OFF, 1'b0);
    clk1(1'b1, 1'b0);
    clk1(1'b0, 1'b0);
    chk("rst_repress_crank", S_CRANK, 1'b0);
    for (int i = 0; i < 3; i++) clk1(1'b1, 1'b0);
    chk("rst_crank_cnt_3", S_CRANK, 1'b0);
    clk1(1'b1, 1'b0);
    chk("rst_crank_cnt_4", S_RUN, 1'b0);
    pulse_reset("rst_mid_run");
    clk1(1'b0, 1'b0);
    chk("after_rst_run", S_OFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
